// File: rtl/mem_responder_if.sv
// mem_responder_if: request/response bundle between the data-cache miss and
// write-back initiator (master) and the backing-memory responder (slave).
//
//   req_valid / req_ready  : request handshake, initiator -> responder
//   req_we                 : 1 = single-word write, 0 = line read
//   req_addr               : byte address (bits [1:0] ignored)
//   req_wdata              : write data, sampled at accept
//   rsp_valid / rsp_ready  : read-beat handshake, responder -> initiator
//   rsp_data / rsp_idx     : beat data and its word index within the line
//   rsp_last               : final beat of a burst
//   wr_ack                 : one-cycle pulse, write committed
interface mem_responder_if #(
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int IDX_W = $clog2(LINE_WORDS);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [IDX_W-1:0]  rsp_idx;
    logic              rsp_last;
    logic              wr_ack;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, wr_ack
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, wr_ack
    );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: backing memory behind the data cache. Accepts one request at
// a time; after LATENCY wait cycles it answers a read with a critical-word-
// first line burst or a write with a single-cycle wr_ack.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous, active-low reset
//   bus  : mem_responder_if slave modport (request, read beats, wr_ack)
//
// The word array has no reset; never-written words read back as X.
module mem_responder #(
    parameter int DATA_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 3
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus
);
    localparam int IDX_W = $clog2(LINE_WORDS);
    localparam int AW    = $clog2(DEPTH_WORDS);
    localparam logic [AW-1:0] LINE_MASK = AW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST,
        S_WACK
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        lat_cnt_q, lat_cnt_d;
    logic [IDX_W-1:0]  beat_q, beat_d;
    logic              we_q, we_d;
    logic [AW-1:0]     widx_q, widx_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rsp_data_q;
    // Holds req_ready low until the first edge after reset is released.
    logic              alive_q;

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic              rd_en;
    logic [IDX_W-1:0]  rd_low;
    logic [AW-1:0]     rd_addr;
    logic              mem_we;
    logic [AW-1:0]     req_widx;
    logic [IDX_W-1:0]  widx_low;
    logic [IDX_W-1:0]  cur_idx;
    logic              unused_addr_bits;

    assign req_widx = bus.req_addr[AW+1:2];
    assign unused_addr_bits = ^{bus.req_addr[31:AW+2], bus.req_addr[1:0]};

    assign widx_low = widx_q[IDX_W-1:0];
    // Index arithmetic is IDX_W bits wide, so the wrap within the line is free.
    assign cur_idx  = widx_low + beat_q;
    assign rd_addr  = (widx_q & ~LINE_MASK) | AW'(rd_low);

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        beat_d    = beat_q;
        we_d      = we_q;
        widx_d    = widx_q;
        wdata_d   = wdata_q;
        rd_en     = 1'b0;
        rd_low    = cur_idx;
        mem_we    = 1'b0;

        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        bus.rsp_idx   = '0;
        bus.rsp_last  = 1'b0;
        bus.wr_ack    = 1'b0;
        bus.rsp_data  = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                bus.req_ready = alive_q;
                if (bus.req_valid && alive_q) begin
                    we_d      = bus.req_we;
                    widx_d    = req_widx;
                    wdata_d   = bus.req_wdata;
                    lat_cnt_d = 4'(LATENCY);
                    state_d   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (lat_cnt_q == 4'd0) begin
                    if (we_q) begin
                        mem_we  = 1'b1;
                        state_d = S_WACK;
                    end else begin
                        // Prefetch the critical word so beat 0 is ready on entry.
                        beat_d  = '0;
                        rd_en   = 1'b1;
                        rd_low  = widx_low;
                        state_d = S_BURST;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 4'd1;
                end
            end
            S_BURST: begin
                bus.rsp_valid = 1'b1;
                bus.rsp_idx   = cur_idx;
                bus.rsp_last  = (beat_q == IDX_W'(LINE_WORDS - 1));
                if (bus.rsp_ready) begin
                    if (beat_q == IDX_W'(LINE_WORDS - 1)) begin
                        beat_d  = '0;
                        state_d = S_IDLE;
                    end else begin
                        // Fetch the next beat's word; data register otherwise holds.
                        beat_d = beat_q + IDX_W'(1);
                        rd_en  = 1'b1;
                        rd_low = cur_idx + IDX_W'(1);
                    end
                end
            end
            S_WACK: begin
                bus.wr_ack = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            lat_cnt_q  <= 4'd0;
            beat_q     <= '0;
            we_q       <= 1'b0;
            widx_q     <= '0;
            wdata_q    <= '0;
            rsp_data_q <= '0;
            alive_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            beat_q    <= beat_d;
            we_q      <= we_d;
            widx_q    <= widx_d;
            wdata_q   <= wdata_d;
            alive_q   <= 1'b1;
            if (rd_en) begin
                rsp_data_q <= mem[rd_addr];
            end
        end
    end

    // Array write port: no reset, so contents survive a reset. A write still in
    // WAIT when reset hits never reaches this edge and is simply lost.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[widx_q] <= wdata_q;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
    localparam int DATA_W      = 32;
    localparam int LINE_WORDS  = 4;
    localparam int DEPTH_WORDS = 1024;
    localparam int LATENCY     = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mem_responder_if #(.DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS)) bus ();

    mem_responder #(
        .DATA_W(DATA_W), .LINE_WORDS(LINE_WORDS),
        .DEPTH_WORDS(DEPTH_WORDS), .LATENCY(LATENCY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        bit                is_ack;
        logic [DATA_W-1:0] data;
        bit                known;
        int                idx;
        bit                last;
        int                acc;
        bit                first;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] mdl_mem [DEPTH_WORDS];
    bit                mdl_ok  [DEPTH_WORDS];

    int checks     = 0;
    int failures   = 0;
    int cyc        = 0;
    int beat_num   = 0;
    int bp_left    = 0;
    int stall_seen = 0;
    bit rand_ready = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: samples on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.rsp_valid) begin
                chk("req_ready_low_in_burst", 64'(bus.req_ready), 64'd0);
                if (!bus.rsp_ready) stall_seen++;
                if (exp_q.size() == 0 || exp_q[0].is_ack) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat: got data=%0h idx=%0d expected no beat", bus.rsp_data, bus.rsp_idx);
                end else begin
                    chk("rsp_idx", 64'(bus.rsp_idx), 64'(exp_q[0].idx));
                    chk("rsp_last", 64'(bus.rsp_last), 64'(exp_q[0].last));
                    if (exp_q[0].known) chk("rsp_data", 64'(bus.rsp_data), 64'(exp_q[0].data));
                    if (exp_q[0].first) begin
                        chk("read_latency", 64'(cyc - exp_q[0].acc), 64'(LATENCY + 1));
                        exp_q[0].first = 1'b0;
                    end
                    if (bus.rsp_ready) begin
                        if (exp_q[0].last) begin
                            beat_num = 0;
                            $display("RSP read burst complete, last idx=%0d data=%0h", bus.rsp_idx, bus.rsp_data);
                        end else begin
                            beat_num++;
                        end
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.wr_ack) begin
                if (exp_q.size() == 0 || !exp_q[0].is_ack) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wr_ack: got wr_ack=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    chk("write_latency", 64'(cyc - exp_q[0].acc), 64'(LATENCY + 1));
                    $display("RSP wr_ack");
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // rsp_ready driver: forced stall on beat 1 when armed, else random or high.
    initial begin
        bus.rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (bp_left > 0 && beat_num == 1) begin
                bus.rsp_ready = 1'b0;
                bp_left--;
            end else if (rand_ready) begin
                bus.rsp_ready = ($urandom_range(0, 3) != 0);
            end else begin
                bus.rsp_ready = 1'b1;
            end
        end
    end

    task automatic do_req(input bit we, input logic [31:0] addr,
                          input logic [DATA_W-1:0] wdata, input bit abort);
        int   w;
        int   word;
        int   base;
        int   low;
        exp_t e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        w = 0;
        while (!bus.req_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_accept_timeout: got req_ready=0 expected 1 within 300 cycles");
            bus.req_valid = 1'b0;
            return;
        end
        word = int'((addr >> 2) % DEPTH_WORDS);
        if (!abort) begin
            e.acc   = cyc + 1;
            e.first = 1'b1;
            if (we) begin
                mdl_mem[word] = wdata;
                mdl_ok[word]  = 1'b1;
                e.is_ack = 1'b1;
                e.data   = '0;
                e.known  = 1'b0;
                e.idx    = 0;
                e.last   = 1'b0;
                exp_q.push_back(e);
            end else begin
                base = word - (word % LINE_WORDS);
                low  = word % LINE_WORDS;
                for (int k = 0; k < LINE_WORDS; k++) begin
                    e.is_ack = 1'b0;
                    e.idx    = (low + k) % LINE_WORDS;
                    e.data   = mdl_mem[base + e.idx];
                    e.known  = mdl_ok[base + e.idx];
                    e.last   = (k == LINE_WORDS - 1);
                    e.first  = (k == 0);
                    exp_q.push_back(e);
                end
            end
        end
        $display("REQ %s addr=%08h wdata=%08h%s", we ? "WR" : "RD", addr, wdata, abort ? " (to be aborted)" : "");
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (exp_q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk);
        #3;
        rst = 1'b0;
        exp_q.delete();
        beat_num = 0;
        #1;
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
        chk({tag, "_wr_ack"},    64'(bus.wr_ack),    64'd0);
        chk({tag, "_rsp_last"},  64'(bus.rsp_last),  64'd0);
        chk({tag, "_rsp_idx"},   64'(bus.rsp_idx),   64'd0);
        chk({tag, "_rsp_data"},  64'(bus.rsp_data),  64'd0);
        repeat (3) @(negedge clk);
        chk({tag, "_ready_in_reset"}, 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, "_ready_after"}, 64'(bus.req_ready), 64'd1);
        $display("RST %s done", tag);
    endtask

    initial begin
        int w;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst = 1'b0;

        // Reset then idle.
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
        chk("idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("idle_wr_ack",    64'(bus.wr_ack),    64'd0);
        chk("idle_rsp_last",  64'(bus.rsp_last),  64'd0);
        chk("idle_rsp_idx",   64'(bus.rsp_idx),   64'd0);
        chk("idle_rsp_data",  64'(bus.rsp_data),  64'd0);

        // Fill one line, aligned read, wrapped read.
        do_req(1'b1, 32'h100, 32'h11, 1'b0);
        do_req(1'b1, 32'h104, 32'h22, 1'b0);
        do_req(1'b1, 32'h108, 32'h33, 1'b0);
        do_req(1'b1, 32'h10C, 32'h44, 1'b0);
        do_req(1'b0, 32'h100, 32'h0, 1'b0);
        do_req(1'b0, 32'h108, 32'h0, 1'b0);
        wait_drain();

        // Backpressure on beat 1 of the read of 0x104.
        stall_seen = 0;
        bp_left    = 3;
        do_req(1'b0, 32'h104, 32'h0, 1'b0);
        wait_drain();
        chk("bp_stall_cycles", 64'(stall_seen), 64'd3);

        // Aliasing, and a request held off during the burst.
        do_req(1'b1, 32'h1000, 32'hAA, 1'b0);
        do_req(1'b0, 32'h0, 32'h0, 1'b0);
        do_req(1'b1, 32'h200, 32'h77, 1'b0);
        wait_drain();

        // Reset during WAIT of a write: no ack, old contents kept.
        do_req(1'b1, 32'h200, 32'h55, 1'b1);
        async_reset("rst_wait");
        repeat (10) @(negedge clk);
        do_req(1'b0, 32'h200, 32'h0, 1'b0);
        wait_drain();

        // Reset in the middle of a burst.
        do_req(1'b0, 32'h100, 32'h0, 1'b0);
        w = 0;
        while (!bus.rsp_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        async_reset("rst_burst");
        repeat (4) @(negedge clk);

        // Randomized traffic against the reference model.
        rand_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            logic [31:0] a;
            a = (32'($urandom_range(0, 63)) << 2) | (32'($urandom_range(0, 7)) << 12)
                | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 1'b0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_drain();
        rand_ready = 1'b0;
        repeat (10) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_responder.md
# mem_responder

Backing-memory responder sitting behind the data-side cache of the pipeline. It accepts one request at a time from the cache's miss/write-back initiator over a valid/ready handshake. It answers reads with a critical-word-first line burst and writes with a single-cycle acknowledge, each after a programmable access latency. Contents live in an internal word array with no reset.

## Interface
- `DATA_W`, default 32: word width.
- `LINE_WORDS`, default 4: words per read burst. Power of two, ≥2.
- `DEPTH_WORDS`, default 1024: array depth in words. Power of two.
- `LATENCY`, default 3: wait cycles between request accept and first response. Range 0..15.

Ports (clock and reset first):
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low.
- `req_valid`  in  1: request present.
- `req_ready`  out  1: responder can accept a request.
- `req_we`  in  1: 1 = single-word write, 0 = line read.
- `req_addr`  in  32: byte address. Bits [1:0] are ignored.
- `req_wdata`  in  DATA_W: write data, sampled at accept.
- `rsp_valid`  out  1: read beat valid.
- `rsp_ready`  in  1: initiator accepts the beat.
- `rsp_data`  out  DATA_W: read beat data.
- `rsp_idx`  out  log2(LINE_WORDS): word index of the beat within the line.
- `rsp_last`  out  1: final beat of the burst.
- `wr_ack`  out  1: one-cycle pulse; the write has been committed.

## Operation
- Word index: `widx = req_addr[log2(DEPTH_WORDS)+1:2]`. Higher address bits are dropped, so the array aliases modulo DEPTH_WORDS.
- Line base: `widx` with its low log2(LINE_WORDS) bits cleared.
- The FSM has four states:
  - IDLE: `req_ready`=1. On `req_valid && req_ready`, latch `req_we`, `widx`, `req_wdata`, load `lat_cnt`=LATENCY, then go to WAIT.
  - WAIT: decrement `lat_cnt` each edge. When `lat_cnt`=0 at an edge, go to BURST if the request is a read, or WACK if it is a write. With LATENCY=0, WAIT lasts exactly one cycle.
  - BURST: `rsp_valid`=1.
    - Beat k (k=0..LINE_WORDS-1) returns word `base + ((widx_low + k) mod LINE_WORDS)`, i.e. critical word first, wrapping within the line.
    - `rsp_idx` = `(widx_low + k) mod LINE_WORDS`.
    - `rsp_last`=1 only on k=LINE_WORDS-1.
    - The beat advances only on `rsp_valid && rsp_ready`.
    - While `rsp_ready`=0, `rsp_data`, `rsp_idx` and `rsp_last` hold stable.
    - Acceptance of the last beat returns the FSM to IDLE.
  - WACK: the array word is written at the WAIT→WACK edge. `wr_ack`=1 for exactly the one cycle spent in WACK, then the FSM returns to IDLE unconditionally.
- Only one request is outstanding at a time, so read-after-write ordering holds trivially.
- `req_ready` is 0 in every state except IDLE. Requests presented outside IDLE are held off, not dropped, and not sampled.
- Response data is read from the array at beat time, not at accept time. The array is never written during a burst.
- The array is not reset. Reads of never-written words return X, and the bench must not check them.

## Timing
- Reset (`rst`=0, asynchronous) forces:
  - state IDLE, `lat_cnt`=0, beat counter 0;
  - `rsp_valid`=0, `rsp_last`=0, `rsp_idx`=0, `rsp_data`=0, `wr_ack`=0;
  - `req_ready`=0 while `rst`=0, and `req_ready`=1 from the first cycle after deassertion.
- Reset mid-burst or mid-wait abandons the transaction. No `wr_ack` is issued, and the array keeps its contents (a pending write is lost if reset arrives before the WAIT→WACK edge).
- Read latency, with the request accepted at edge E0: first beat visible in the cycle after edge E0+LATENCY+1. For LATENCY=3 that is 4 cycles after accept. With `rsp_ready` held high, one beat per cycle, so the burst spans LINE_WORDS cycles.
- Write latency: `wr_ack` is high in the cycle after edge E0+LATENCY+1, and the array is updated at that same edge.
- After IDLE is re-entered, `req_ready`=1 for at least one cycle before the next accept, so the minimum request spacing is one idle cycle.
- Beat counter and `lat_cnt` have no overflow paths: the beat counter is log2(LINE_WORDS) bits and wraps only at burst end; `lat_cnt` is 4 bits.

## Test plan
- Reset then idle: hold `rst`=0 for 3 cycles, release → `req_ready`=1, `rsp_valid`=0, `wr_ack`=0. Assert `rst`=0 asynchronously between edges → outputs clear immediately.
- Write then aligned read: write 0x11,0x22,0x33,0x44 to byte addresses 0x100..0x10C, then read 0x100 → each write produces `wr_ack` 4 cycles after its accept. The read returns beats 0x11,0x22,0x33,0x44 with `rsp_idx` 0,1,2,3, `rsp_last` only on the 4th beat, and the first beat 4 cycles after accept.
- Critical-word-first wrap: after the preceding writes, read 0x108 → data 0x33,0x44,0x11,0x22 with `rsp_idx` 2,3,0,1.
- Backpressure: during the read of 0x104, drop `rsp_ready` for 3 cycles on beat 1 → `rsp_data`=0x33 and `rsp_idx`=2 held stable, with no beat lost or duplicated. `req_ready` stays 0 until the last beat is accepted.
- Aliasing and held-off request:
  - Write 0xAA to 0x1000 (aliases word 0 when DEPTH_WORDS=1024), then read 0x0 → first beat 0xAA.
  - Assert `req_valid` during that burst → not accepted until IDLE, then serviced normally.
- Reset mid-operation: accept a write of 0x55 to 0x200, assert `rst`=0 during WAIT → no `wr_ack`. A later read of 0x200 (after a known prior write of 0x77) returns 0x77.
